fetch_bus_arbiter: RTL and testbench
====================================

Name: fetch_bus_arbiter

Overview:
Owns the shared memory bus feeding Pipeline Stage 0. Arbitrates each cycle between instruction fetch (default owner), single-cycle data accesses from the load/store stage, and multi-cycle external DMA bursts. Drives Stage 0's BusRequest and FetchSurpress inputs, and the PCRA0/PCRA1 increment strobes. Guarantees fetch forward progress via a bounded DMA burst length.

Parameters:
DMA_MAX_BURST, 8, max consecutive DMA-owned cycles before one forced fetch slot (range 1..255)
BURST_W, 8, width of the DMA burst counter

Ports:
ClockIn  in  1  sole clock, all state on rising edge
ResetIn_n  in  1  synchronous, active-low reset
HaltReq  in  1  CPU halt; blocks fetch while high
DataReq  in  1  load/store stage requests one bus cycle
DmaReq  in  1  external master requests bus; held high for the whole burst
Flags_5_PCRA_Flip  in  1  selects active PC register (0=PCRA0, 1=PCRA1)
BusRequest  out  1  to Stage 0: bus taken by a non-fetch owner this cycle
FetchSurpress  out  1  to Stage 0: do not latch MEMDATA; inject NOP
IncPCRA0  out  1  increment PCRA0 (fetch cycle, flip=0)
IncPCRA1  out  1  increment PCRA1 (fetch cycle, flip=1)
DataGrant  out  1  bus owned by load/store stage this cycle
DmaGrant  out  1  bus owned by DMA master this cycle
BusOwner  out  2  0=FETCH 1=DATA 2=DMA 3=IDLE

Behaviour:
- Clock ClockIn only; reset ResetIn_n synchronous active-low. Reset state IDLE, burst count 0.
- Reset output values: BusRequest=1, FetchSurpress=1, IncPCRA0=0, IncPCRA1=0, DataGrant=0, DmaGrant=0, BusOwner=3. Reset asserted mid-burst drops DmaGrant on the next edge, with no turnaround cycle.
- Moore FSM, registered state. Requests sampled at edge N; grant visible during cycle N+1. Grants are decoded from state only.
- States: FETCH, DATA, DMA, TURN (1-cycle idle after DMA), IDLE.
- Next-state priority, evaluated from any state except DMA/TURN:
  1. DataReq -> DATA.
  2. DmaReq -> DMA, with count cleared to 1.
  3. HaltReq -> IDLE.
  4. Otherwise -> FETCH.
- DATA is always exactly one cycle. If DataReq is still high in DATA, a second DATA cycle is granted (a new request each cycle).
- DMA transitions:
  - DmaReq low -> TURN.
  - DmaReq high and count==DMA_MAX_BURST -> TURN, then a forced FETCH (or IDLE if HaltReq). DataReq and DmaReq are ignored for that one slot, and the count resets.
  - Otherwise stay in DMA, count+1 (saturating at 2^BURST_W-1).
- TURN: all grants 0, BusOwner=3. Next state uses normal priority, except the forced-fetch case above.
- Output decode per state:
  - FETCH: BusRequest=0, FetchSurpress=0, IncPCRA{Flip}=1, other Inc=0, BusOwner=0.
  - DATA: DataGrant=1, BusRequest=1, FetchSurpress=1, BusOwner=1.
  - DMA: DmaGrant=1, BusRequest=1, FetchSurpress=1, BusOwner=2.
  - IDLE and TURN: BusRequest=0, FetchSurpress=1, no Inc, BusOwner=3.
- IncPCRA0 and IncPCRA1 are mutually exclusive, derived combinationally from FETCH state and the current Flags_5_PCRA_Flip. A flip change takes effect the same cycle.
- At most one of {fetch, DataGrant, DmaGrant} is active per cycle.
- DataReq and DmaReq arriving simultaneously: DATA wins; DMA is granted the cycle after, if DmaReq is still high.
- HaltReq does not block DATA or DMA. On a HaltReq deassert, FETCH resumes one cycle later.

Decomposition:
- Shared package: bus_owner_t enum (FETCH=0, DATA=1, DMA=2, IDLE=3) and the arbiter state encoding. Later stages decode BusOwner from this package.
- One natural sub-module: dma_burst_counter (load/increment/saturate, compare to DMA_MAX_BURST, outputs limit_hit).

Test Plan:
- Reset release with no requests, Flip=0 -> cycle 1 FETCH, IncPCRA0=1 every cycle, BusOwner=0; Flip=1 -> IncPCRA1=1, IncPCRA0=0 the same cycle.
- DataReq single pulse at cycle 5 -> DataGrant=1, FetchSurpress=1, no Inc in cycle 6; FETCH again in cycle 7.
- DmaReq held 20 cycles, DMA_MAX_BURST=8 -> DmaGrant for 8 cycles, TURN, one FETCH with Inc=1, then DmaGrant resumes; pattern repeats until release; after release, 1 TURN then FETCH.
- DataReq and DmaReq both rise at cycle 3 -> cycle 4 DATA, cycle 5 DMA; never two grants in one cycle (assertion checked every cycle).
- HaltReq high 4 cycles during FETCH -> BusOwner=3, FetchSurpress=1, no Inc for 4 cycles; a DataReq during the halt is still granted.
- ResetIn_n low for one cycle mid-DMA (count=5) -> next cycle DmaGrant=0, BusOwner=3, outputs at reset values; after release, count restarts at 1 on the next DMA grant.

Source files
------------

// File: rtl/fetch_bus_arbiter_pkg.sv
// ============================================================================
// fetch_bus_arbiter_pkg: bus owner encoding and arbiter state type. Rev 1.0
// ============================================================================
`default_nettype none

package fetch_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      BUS_FETCH = 2'd0,
      BUS_DATA  = 2'd1,
      BUS_DMA   = 2'd2,
      BUS_IDLE  = 2'd3
   } bus_owner_t;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_DATA  = 3'd1,
      ST_DMA   = 3'd2,
      ST_TURN  = 3'd3,
      ST_IDLE  = 3'd4
   } arb_state_t;

   function automatic bus_owner_t state_owner(input arb_state_t s);
      case (s)
         ST_FETCH: return BUS_FETCH;
         ST_DATA:  return BUS_DATA;
         ST_DMA:   return BUS_DMA;
         default:  return BUS_IDLE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_bus_arbiter_dma_burst_counter.sv
// ============================================================================
// dma_burst_counter: counts DMA-owned cycles, flags the burst limit. Rev 1.0
// ============================================================================
`default_nettype none

module dma_burst_counter #(
   parameter int DMA_MAX_BURST = 8,
   parameter int BURST_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic inc,
   input  logic clear,
   output logic limit_hit
);

   logic [BURST_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (load) begin
         count <= BURST_W'(1);
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign limit_hit = (count == BURST_W'(DMA_MAX_BURST));

endmodule

`default_nettype wire

// File: rtl/fetch_bus_arbiter.sv
// ============================================================================
// fetch_bus_arbiter: Stage 0 bus arbiter (fetch / load-store / DMA). Rev 1.0
// ============================================================================
`default_nettype none

module fetch_bus_arbiter #(
   parameter int DMA_MAX_BURST = 8,
   parameter int BURST_W       = 8
) (
   input  logic       ClockIn,
   input  logic       ResetIn_n,
   input  logic       HaltReq,
   input  logic       DataReq,
   input  logic       DmaReq,
   input  logic       Flags_5_PCRA_Flip,
   output logic       BusRequest,
   output logic       FetchSurpress,
   output logic       IncPCRA0,
   output logic       IncPCRA1,
   output logic       DataGrant,
   output logic       DmaGrant,
   output logic [1:0] BusOwner
);

   import fetch_bus_arbiter_pkg::*;

   arb_state_t state;
   arb_state_t next_state;
   arb_state_t normal_next;
   logic       normal_load;
   logic       forced_fetch;
   logic       next_forced;
   logic       fetch_slot;
   logic       cnt_load;
   logic       cnt_inc;
   logic       cnt_clear;
   logic       limit_hit;

   dma_burst_counter #(
      .DMA_MAX_BURST (DMA_MAX_BURST),
      .BURST_W       (BURST_W)
   ) u_burst (
      .clk       (ClockIn),
      .rst_n     (ResetIn_n),
      .load      (cnt_load),
      .inc       (cnt_inc),
      .clear     (cnt_clear),
      .limit_hit (limit_hit)
   );

   always_comb begin
      normal_next = ST_FETCH;
      normal_load = 1'b0;
      if (DataReq) begin
         normal_next = ST_DATA;
      end else if (DmaReq) begin
         normal_next = ST_DMA;
         normal_load = 1'b1;
      end else if (HaltReq) begin
         normal_next = ST_IDLE;
      end
   end

   always_comb begin
      next_state  = normal_next;
      next_forced = 1'b0;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
      cnt_clear   = 1'b0;
      case (state)
         ST_DMA: begin
            if (!DmaReq) begin
               next_state = ST_TURN;
               cnt_clear  = 1'b1;
            end else if (limit_hit) begin
               // Burst limit reached: reserve the slot after TURN for fetch.
               next_state  = ST_TURN;
               next_forced = 1'b1;
               cnt_clear   = 1'b1;
            end else begin
               next_state = ST_DMA;
               cnt_inc    = 1'b1;
            end
         end
         ST_TURN: begin
            if (forced_fetch) begin
               next_state = HaltReq ? ST_IDLE : ST_FETCH;
            end else begin
               cnt_load = normal_load;
            end
         end
         default: begin
            cnt_load = normal_load;
         end
      endcase
   end

   // Outputs are registered from the next state so they track the state register.
   always_ff @(posedge ClockIn) begin
      if (!ResetIn_n) begin
         state         <= ST_IDLE;
         forced_fetch  <= 1'b0;
         fetch_slot    <= 1'b0;
         BusRequest    <= 1'b1;
         FetchSurpress <= 1'b1;
         DataGrant     <= 1'b0;
         DmaGrant      <= 1'b0;
         BusOwner      <= BUS_IDLE;
      end else begin
         state         <= next_state;
         forced_fetch  <= next_forced;
         fetch_slot    <= (next_state == ST_FETCH);
         BusRequest    <= (next_state == ST_DATA) || (next_state == ST_DMA);
         FetchSurpress <= (next_state != ST_FETCH);
         DataGrant     <= (next_state == ST_DATA);
         DmaGrant      <= (next_state == ST_DMA);
         BusOwner      <= state_owner(next_state);
      end
   end

   assign IncPCRA0 = fetch_slot & ~Flags_5_PCRA_Flip;
   assign IncPCRA1 = fetch_slot &  Flags_5_PCRA_Flip;

endmodule

`default_nettype wire

// File: tb/tb_fetch_bus_arbiter.sv
// ============================================================================
// tb_fetch_bus_arbiter: directed stimulus with queued expectations. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_bus_arbiter;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       halt_req  = 1'b0;
   logic       data_req  = 1'b0;
   logic       dma_req   = 1'b0;
   logic       flip      = 1'b0;
   logic       bus_request;
   logic       fetch_surpress;
   logic       inc0;
   logic       inc1;
   logic       data_grant;
   logic       dma_grant;
   logic [1:0] bus_owner;

   typedef struct {
      logic [7:0] vec;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   fetch_bus_arbiter #(
      .DMA_MAX_BURST (8),
      .BURST_W       (8)
   ) dut (
      .ClockIn           (clk),
      .ResetIn_n         (rst_n),
      .HaltReq           (halt_req),
      .DataReq           (data_req),
      .DmaReq            (dma_req),
      .Flags_5_PCRA_Flip (flip),
      .BusRequest        (bus_request),
      .FetchSurpress     (fetch_surpress),
      .IncPCRA0          (inc0),
      .IncPCRA1          (inc1),
      .DataGrant         (data_grant),
      .DmaGrant          (dma_grant),
      .BusOwner          (bus_owner)
   );

   always #5 clk = ~clk;

   // {BusRequest, FetchSurpress, IncPCRA0, IncPCRA1, DataGrant, DmaGrant, BusOwner}
   function automatic logic [7:0] expect_vec(input byte code, input logic f);
      case (code)
         "R":     return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
         "F":     return {1'b0, 1'b0, ~f,   f,    1'b0, 1'b0, 2'd0};
         "D":     return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
         "M":     return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
         default: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
      endcase
   endfunction

   // Drive one cycle of inputs before the edge; optionally flip PCRA select after it.
   task automatic step(input string tag, input logic rn, input logic d, input logic m,
                       input logic h, input logic f, input logic f_after, input byte code);
      exp_t e;
      @(negedge clk);
      rst_n    = rn;
      data_req = d;
      dma_req  = m;
      halt_req = h;
      flip     = f;
      e.vec    = expect_vec(code, f_after);
      e.tag    = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      flip = f_after;
   endtask

   task automatic quiet(input string tag, input byte code);
      step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, code);
   endtask

   task automatic dma(input string tag, input byte code);
      step(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, code);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(posedge clk);
         #4;
         tests++;
         if ($countones({inc0 | inc1, data_grant, dma_grant}) > 1) begin
            fails++;
            $display("FAIL one_grant: fetch=%0b data=%0b dma=%0b, required at most one",
                     inc0 | inc1, data_grant, dma_grant);
         end
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus_request, fetch_surpress, inc0, inc1, data_grant, dma_grant, bus_owner};
            tests++;
            if (act !== e.vec) begin
               fails++;
               $display("FAIL %s: got %b required %b (br fs i0 i1 dg dmg own[1:0]) at %0t",
                        e.tag, act, e.vec, $time);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: stimulus did not complete, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin : stimulus
      step("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "R");
      step("reset1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "R");

      quiet("first_fetch", "F");
      quiet("fetch_pcra0", "F");
      step("fetch_pcra1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "F");
      step("flip_late_1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "F");
      step("flip_late_0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "F");

      step("data_pulse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "D");
      quiet("data_after", "F");
      step("data_back2back_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "D");
      step("data_back2back_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "D");
      quiet("data_after2", "F");

      for (int i = 0; i < 8; i++) dma("dma_burst1", "M");
      dma("dma_limit_turn1", "T");
      step("dma_forced_fetch1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "F");
      for (int i = 0; i < 8; i++) dma("dma_burst2", "M");
      dma("dma_limit_turn2", "T");
      dma("dma_forced_fetch2", "F");
      dma("dma_burst3", "M");
      dma("dma_burst3", "M");
      quiet("dma_release_turn", "T");
      quiet("dma_release_fetch", "F");

      step("both_req_data", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "D");
      dma("both_req_dma", "M");
      quiet("both_req_turn", "T");
      quiet("both_req_fetch", "F");

      step("halt_1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "I");
      step("halt_2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "I");
      step("halt_data", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "D");
      step("halt_4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "I");
      quiet("halt_release", "F");

      for (int i = 0; i < 5; i++) dma("pre_reset_dma", "M");
      step("reset_mid_dma", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "R");
      for (int i = 0; i < 8; i++) dma("post_reset_burst", "M");
      dma("post_reset_limit", "T");
      quiet("post_reset_forced", "F");
      quiet("post_reset_fetch", "F");

      @(posedge clk);
      #6;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
